instr_packer: RTL
=================

# instr_packer

Packs decoded MIPS instruction fields back into 32-bit machine words and streams them, with sequential instruction-memory addresses, to the instruction-memory loader. It is the encode-side counterpart of the CPU's field splitter. The testbench program generator and the self-loading IM path use it to build programs field-by-field. Input and output use valid/ready handshakes, with a 4-entry FIFO between them.

## Interface
- `BASE_ADDR`, default 32'h0000_3000: address of the first emitted word and of every wrap.
- `LAST_ADDR`, default 32'h0000_6FFC: last word address before the wrap.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high. Clears the FIFO, address counter and error flag.
- `restart` input 1: synchronous. Has the same effect as `reset`, but takes effect on the clock edge.
- `in_valid` input 1: field set on the inputs is valid.
- `in_ready` output 1: the packer can accept a field set this cycle.
- `fmt` input 2: encoding format. 00 = R, 01 = I, 10 = J, 11 = NOP.
- `opcode` input 6, `rs` input 5, `rt` input 5, `rd` input 5, `shamt` input 5, `funct` input 6, `imm16` input 16, `instr_index` input 26: instruction fields.
- `out_valid` output 1: head word is valid.
- `out_ready` input 1: consumer takes the head word.
- `out_addr` output 32: IM byte address of the head word.
- `out_instr` output 32: packed head word.
- `count` output 3: FIFO occupancy, 0 to 4.
- `err` output 1: sticky format-violation flag.

## Operation
- Packing is combinational on the inputs.
  - R format: {opcode, rs, rt, rd, shamt, funct}.
  - I format: {opcode, rs, rt, imm16}.
  - J format: {opcode, instr_index}.
  - NOP format: 32'h0000_0000.
- Push: `in_valid && in_ready` at a rising edge enqueues the packed word.
  - `in_ready = (count != 4)`.
  - There is no bypass when full. A push and pop in the same edge while full is impossible, because `in_ready` = 0.
- Pop: `out_valid && out_ready` at a rising edge dequeues the head word.
  - The same edge advances the address counter by 4.
  - `out_valid = (count != 0)`.
- Push and pop in the same edge with 0 < count < 4: `count` is unchanged and the word order is preserved.
- Address counter:
  - Starts at `BASE_ADDR`.
  - On a pop at `LAST_ADDR`, wraps to `BASE_ADDR`.
  - `out_addr` is the counter value for the current head word.
- FIFO pointers are 2 bits and wrap modulo 4. `count` is held separately as 3 bits.
- `restart`:
  - Clears the FIFO and sets the counter to `BASE_ADDR`.
  - It overrides a push or pop on the same edge: nothing is enqueued and the address does not advance.
  - `err` is cleared.
- Mid-operation `reset` takes effect immediately, without waiting for a clock edge. Queued words are discarded.

## Timing
- Reset values:
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `count` = 0.
  - `out_addr` = `BASE_ADDR`.
  - `out_instr` = 32'h0.
  - `err` = 0.
- Latency: a word pushed at edge N into an empty FIFO shows on `out_valid` and `out_instr` right after edge N, so it can pop at edge N+1.
- `in_ready`, `out_valid` and `count` depend only on registered state. There is no combinational path from `in_valid` or `out_ready` to them.
- `out_instr` and `out_addr` stay stable while `out_valid && !out_ready`.

## Configuration
- `INSTR_PACKER_FMT_CHECK_EN` defined:
  - Rejects an R-format input whose `opcode` != 6'h00.
  - Rejects a J-format input whose `opcode` is not 6'h02 or 6'h03.
  - A rejected input is still handshaken (`in_ready` behaves normally) but is not enqueued.
  - `err` goes to 1 on the following edge and stays set until `reset` or `restart`.
- `INSTR_PACKER_FMT_CHECK_EN` undefined: every input is packed as given, and `err` is tied to 0.

## Test plan
- R-format encode:
  - Stimulus: `fmt`=00, `opcode`=0, `rs`=2, `rt`=3, `rd`=1, `shamt`=0, `funct`=0x20, `out_ready`=1.
  - Response: `out_instr`=0x00430820 at `out_addr`=0x3000. The next word appears at 0x3004.
- I-format and J-format encode:
  - ori: `opcode`=0x0D, `rs`=0, `rt`=8, `imm16`=0x1234 -> 0x34081234.
  - jal: `opcode`=0x03, `instr_index`=0x0000C03 -> 0x0C000C03. Both appear in order at consecutive addresses.
- Full backpressure:
  - Stimulus: `out_ready`=0, 5 back-to-back pushes.
  - Response: `in_ready` drops after the 4th push, `count`=4, and the 5th word is held off.
  - Then raise `out_ready` for 1 cycle: `count`=3, `in_ready`=1, the 5th word is accepted, and all words leave in FIFO order.
- Address wrap: pop 4096 words. The 4096th word has `out_addr`=0x6FFC and the 4097th has 0x3000.
- Reset and restart mid-operation:
  - With 3 words queued, assert `reset` between clock edges. `count` goes to 0 and `out_valid` to 0 immediately.
  - With words queued and a push on the same edge, `restart` gives `count`=0 and `out_addr`=0x3000.
- Format check (only with `INSTR_PACKER_FMT_CHECK_EN`): an R-format input with `opcode`=0x08 is not enqueued (`count` unchanged) and `err`=1. `err` stays 1 until `restart`.

Source files
------------

// File: rtl/instr_packer.sv
// Packs MIPS instruction fields into 32-bit words and streams them through a 4-entry FIFO with
// sequential IM addresses. Define INSTR_PACKER_FMT_CHECK_EN to reject malformed R/J inputs.
module instr_packer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter logic [31:0] LAST_ADDR = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  fmt,
    input  logic [5:0]  opcode,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_addr,
    output logic [31:0] out_instr,
    output logic [2:0]  count,
    output logic        err
);

    localparam logic [1:0] FmtR   = 2'b00;
    localparam logic [1:0] FmtI   = 2'b01;
    localparam logic [1:0] FmtJ   = 2'b10;

    logic [31:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_count;
    logic [31:0] r_addr;

    logic [31:0] w_packed;
    logic        w_fmt_ok;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;
    logic [2:0]  w_count_next;
    logic [31:0] w_addr_next;

    always_comb begin
        w_packed = 32'h0000_0000;
        case (fmt)
            FmtR:    w_packed = {opcode, rs, rt, rd, shamt, funct};
            FmtI:    w_packed = {opcode, rs, rt, imm16};
            FmtJ:    w_packed = {opcode, instr_index};
            default: w_packed = 32'h0000_0000;
        endcase
    end

`ifdef INSTR_PACKER_FMT_CHECK_EN
    logic r_err;

    always_comb begin
        w_fmt_ok = 1'b1;
        if (fmt == FmtR && opcode != 6'h00) begin
            w_fmt_ok = 1'b0;
        end
        if (fmt == FmtJ && opcode != 6'h02 && opcode != 6'h03) begin
            w_fmt_ok = 1'b0;
        end
    end

    // A rejected field set still completes its handshake; it just never reaches the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (restart) begin
            r_err <= 1'b0;
        end else if (w_accept && !w_fmt_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_fmt_ok = 1'b1;
    assign err      = 1'b0;
`endif

    assign in_ready  = (r_count != 3'd4);
    assign out_valid = (r_count != 3'd0);
    assign w_accept  = in_valid && in_ready;
    assign w_push    = w_accept && w_fmt_ok && !restart;
    assign w_pop     = out_valid && out_ready && !restart;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 3'd1;
            2'b01:   w_count_next = r_count - 3'd1;
            default: w_count_next = r_count;
        endcase
    end

    assign w_addr_next = (r_addr == LAST_ADDR) ? BASE_ADDR : r_addr + 32'd4;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_addr   <= BASE_ADDR;
        end else if (restart) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 3'd0;
            r_addr   <= BASE_ADDR;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
                r_addr   <= w_addr_next;
            end
            r_count <= w_count_next;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_packed;
        end
    end

    assign out_instr = out_valid ? r_mem[r_rd_ptr] : 32'h0000_0000;
    assign out_addr  = r_addr;
    assign count     = r_count;

endmodule
